// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer plus a saturating-counter pattern
//   history table. The table index is either bimodal (GHR_BITS = 0) or gshare
//   (PC index XOR global history). The fetch-side lookup is combinational.
//   Updates come from branches resolved in the MEMORY stage and are applied
//   on the rising clock edge. The block also keeps 32-bit performance
//   counters.
//
// Ports
//   clk, nrst        clock; asynchronous active-low reset
//   fetch_pc         PC being fetched
//   fetch_predict    predict taken at fetch_pc
//   fetch_target     predicted target (fetch_pc+4 on a BTB miss)
//   mem_branch       valid resolved control transfer in MEMORY
//   mem_uncond       resolved instruction is JAL/JALR
//   mem_pc           PC of the resolved instruction
//   mem_predict      direction originally predicted
//   mem_target       target originally predicted
//   mem_taken        resolved direction
//   mem_target_res   resolved target
//   mem_branch_miss  misprediction this cycle
//   mem_flush        flush request to the hazard unit
//   perf_branches    resolved-branch count (wraps)
//   perf_misses      misprediction count (wraps)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] fetch_pc,
    output logic        fetch_predict,
    output logic [31:0] fetch_target,
    input  logic        mem_branch,
    input  logic        mem_uncond,
    input  logic [31:0] mem_pc,
    input  logic        mem_predict,
    input  logic [31:0] mem_target,
    input  logic        mem_taken,
    input  logic [31:0] mem_target_res,
    output logic        mem_branch_miss,
    output logic        mem_flush,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_misses
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    // The history register keeps at least one bit so that its declaration
    // stays legal in bimodal mode. In that mode it is held at zero.
    localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);

    // Saturating up/down step of a PHT counter
    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                     input logic up);
        logic [CTR_BITS-1:0] n;
        if (up) begin
            n = (c == CTR_MAX) ? c : c + CTR_ONE;
        end else begin
            n = (c == CTR_ZERO) ? c : c - CTR_ONE;
        end
        return n;
    endfunction

    logic [BTB_ENTRIES-1:0] valid_r;
    logic [BTB_ENTRIES-1:0] uncond_r;
    logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
    logic [31:0]            target_r [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    pht_r    [BTB_ENTRIES];
    logic [GW-1:0]          ghr_r;

    logic [IDX-1:0]      fetch_idx_s, mem_idx_s, ghr_ext_s;
    logic [IDX-1:0]      fetch_pht_idx_s, mem_pht_idx_s;
    logic [TAG_W-1:0]    fetch_tag_s, mem_tag_s;
    logic                fetch_hit_s;
    logic [CTR_BITS-1:0] fetch_ctr_s;
    logic                miss_s;
    logic                unused_s;

    assign fetch_idx_s     = fetch_pc[IDX+1:2];
    assign fetch_tag_s     = fetch_pc[31:IDX+2];
    assign mem_idx_s       = mem_pc[IDX+1:2];
    assign mem_tag_s       = mem_pc[31:IDX+2];
    assign fetch_pht_idx_s = fetch_idx_s ^ ghr_ext_s;
    assign mem_pht_idx_s   = mem_idx_s ^ ghr_ext_s;
    // Instructions are word aligned, so PC bits [1:0] carry no information.
    assign unused_s        = ^{fetch_pc[1:0], mem_pc[1:0]};

    // Zero-extend the global history to the index width (zero in bimodal mode)
    always_comb begin
        ghr_ext_s = {IDX{1'b0}};
        if (GHR_BITS > 0) begin
            ghr_ext_s = IDX'(ghr_r);
        end else begin
            ghr_ext_s = {IDX{1'b0}};
        end
    end

    // Fetch-side lookup. The registered arrays are read here, so a
    // same-cycle update is only seen from the next cycle.
    always_comb begin
        fetch_hit_s   = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
        fetch_ctr_s   = pht_r[fetch_pht_idx_s];
        fetch_predict = fetch_hit_s & (uncond_r[fetch_idx_s] | fetch_ctr_s[CTR_BITS-1]);
        if (fetch_hit_s) begin
            fetch_target = target_r[fetch_idx_s];
        end else begin
            fetch_target = fetch_pc + 32'd4;
        end
    end

    // Misprediction: the direction differs, or a taken prediction had the
    // wrong target
    always_comb begin
        miss_s = 1'b0;
        if (mem_branch) begin
            miss_s = (mem_predict != mem_taken) ||
                     (mem_taken && mem_predict && (mem_target != mem_target_res));
        end else begin
            miss_s = 1'b0;
        end
    end

    assign mem_branch_miss = miss_s;
    assign mem_flush       = miss_s;

    // Reset-bearing predictor state: valid/uncond bits, PHT, GHR, perf counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_r       <= {BTB_ENTRIES{1'b0}};
            uncond_r      <= {BTB_ENTRIES{1'b0}};
            ghr_r         <= {GW{1'b0}};
            perf_branches <= 32'd0;
            perf_misses   <= 32'd0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (mem_branch) begin
            // Only conditional branches train direction and history.
            if (!mem_uncond) begin
                pht_r[mem_pht_idx_s] <= ctr_next(pht_r[mem_pht_idx_s], mem_taken);
                if (GHR_BITS > 0) begin
                    ghr_r <= GW'({ghr_r, mem_taken});
                end
            end
            // Not-taken resolutions never invalidate an entry.
            if (mem_taken) begin
                valid_r[mem_idx_s]  <= 1'b1;
                uncond_r[mem_idx_s] <= mem_uncond;
            end
            perf_branches <= perf_branches + 32'd1;
            if (miss_s) begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end

    // Tag/target storage. These are guarded by the valid bits, so they need
    // no reset.
    always_ff @(posedge clk) begin
        if (mem_branch && mem_taken) begin
            tag_r[mem_idx_s]    <= mem_tag_s;
            target_r[mem_idx_s] <= mem_target_res;
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the fixed single-mode branch unit used by the 5-stage RV32 pipeline.
- Provides a direct-mapped branch target buffer (BTB) and saturating-counter pattern history table (PHT), selectable bimodal or gshare indexing, and 32-bit performance counters.
- Fetch-side lookup is combinational, so the prediction is available in the fetch cycle.
- Update is synchronous, non-speculative, and happens at branch resolution in the MEMORY stage.

Parameters:
- BTB_ENTRIES, 16: BTB and PHT entry count; power of two, 2..256.
- CTR_BITS, 2: PHT counter width, 1..4.
- GHR_BITS, 0: global history length. 0 = bimodal; 1..log2(BTB_ENTRIES) = gshare.

Ports:
- clk  in  1  clock
- nrst  in  1  reset; nrst asynchronous, active-low; clock clk.
- fetch_pc  in  32  PC being fetched
- fetch_predict  out  1  predict taken at fetch_pc
- fetch_target  out  32  predicted target
- mem_branch  in  1  valid resolved control-transfer instruction in MEMORY this cycle
- mem_uncond  in  1  resolved instruction is JAL/JALR
- mem_pc  in  32  PC of the resolved instruction
- mem_predict  in  1  prediction originally made for it
- mem_target  in  32  target originally predicted
- mem_taken  in  1  resolved direction
- mem_target_res  in  32  resolved target
- mem_branch_miss  out  1  misprediction
- mem_flush  out  1  flush request to the hazard unit
- perf_branches  out  32  resolved-branch count
- perf_misses  out  32  mispredict count

Behaviour:
- Index and tag. IDX = log2(BTB_ENTRIES).
  - BTB index = pc[IDX+1:2]; tag = pc[31:IDX+2].
  - PHT index = pc[IDX+1:2] XOR zero-extended GHR. With GHR_BITS=0 it equals the BTB index.
- BTB entry: valid, tag, target[31:0], uncond.
- Fetch (combinational):
  - hit = valid & tag match.
  - fetch_predict = hit & (uncond | PHT counter MSB).
  - fetch_target = entry target when hit, else fetch_pc+4.
- Resolution (combinational):
  - mem_branch_miss = mem_branch & ((mem_predict != mem_taken) | (mem_taken & mem_predict & mem_target != mem_target_res)).
  - mem_flush = mem_branch_miss.
  - Both are 0 when mem_branch=0, regardless of other inputs.
- Update on posedge clk when mem_branch=1:
  - Conditional branch (mem_uncond=0):
    - PHT[mem_pc index XOR GHR] saturating +1 if taken, -1 if not.
    - GHR <= {GHR[GHR_BITS-2:0], mem_taken}.
  - Unconditional: PHT and GHR unchanged.
  - If mem_taken: BTB[idx] <= {1, tag, mem_target_res, mem_uncond}. This overwrites any aliasing entry and corrects a wrong target.
  - Not taken: BTB entry unchanged (never invalidated).
  - perf_branches += 1; perf_misses += 1 if miss. Both wrap modulo 2^32.
- Read/write collision: a fetch lookup to an index being updated in the same cycle returns the pre-update contents. The new value is visible from the next cycle.
- Reset (async, any time, including mid-update):
  - All BTB valid bits = 0.
  - PHT counters = weakly not-taken, 2^(CTR_BITS-1)-1 (CTR_BITS=1 → 0).
  - GHR = 0; perf counters = 0.
  - Resulting outputs: fetch_predict=0, fetch_target=fetch_pc+4, mem_branch_miss=0, mem_flush=0.
  - BTB tag/target storage need not be reset.
- Latency: prediction 0 cycles; an update affects predictions from the cycle after the resolving edge.
- Storage is flops; no RAM macro inference is required.

Test Plan:
1. Reset, defaults (16 entries, CTR_BITS=2), fetch_pc=0x100 → fetch_predict=0, fetch_target=0x104, mem_flush=0, perf counters 0.
2. Resolve mem_pc=0x100, taken, target 0x80, mem_predict=0 → mem_branch_miss=mem_flush=1 that cycle. Next cycle, fetch_pc=0x100 → fetch_predict=1 (counter 1→2), fetch_target=0x80; perf_branches=1, perf_misses=1.
3. Alias: after scenario 2, fetch_pc=0x140 (same index 0, different tag) → fetch_predict=0, fetch_target=0x144.
4. Saturation: from counter 2, three taken then two not-taken updates at 0x100 → counter 3,3,3,2,1; fetch_predict=1 after the first not-taken, 0 after the second; BTB target still 0x80.
5. JALR target miss: mem_uncond=1, mem_pc=0x200, mem_predict=1, mem_target=0x300, mem_taken=1, mem_target_res=0x340 → miss=1. Next cycle fetch 0x200 → predict=1, target 0x340; GHR and PHT unchanged.
6. GHR_BITS=2, plus reset mid-run:
   - Conditional taken updates at 0x100 then 0x104 → GHR=2'b11. A later update at 0x100 modifies PHT index 3, not 0.
   - Asserting nrst mid-cycle → fetch_predict=0 immediately; perf counters read 0.
